// File: rtl/mv_pkg.sv
// mv_pkg: shared types and constants for the matrix-vector row sequencer.
//   state_t          - sequencer FSM states
//   *_DEF            - default datapath geometry (columns, lanes, rows, MAC latency)
//   BEATS/COL_W/ROW_W - derived beat count and index widths for the defaults
//   clamp_rows()     - limits a requested row count to the supported maximum
package mv_pkg;

  localparam int VEC_LEN_DEF  = 128;
  localparam int LANES_DEF    = 8;
  localparam int ROWS_DEF     = 128;
  localparam int PIPE_LAT_DEF = 2;

  localparam int BEATS = VEC_LEN_DEF / LANES_DEF;
  localparam int COL_W = $clog2(VEC_LEN_DEF);
  localparam int ROW_W = $clog2(ROWS_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requests above the supported row count run the full matrix instead of wrapping.
  function automatic int clamp_rows(input int req, input int max_rows);
    if (req > max_rows) begin
      return max_rows;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/mv_wb_delay.sv
// mv_wb_delay: DEPTH-stage shift register carrying a write strobe plus its
// address, used to line the result write up with the MAC pipeline latency.
//   clk       - clock; stages advance on the falling edge like the lane datapath
//   reset     - asynchronous active-low reset, clears every stage
//   in_valid  - strobe entering stage 0 this cycle
//   in_addr   - address travelling with in_valid
//   out_valid - strobe leaving the last stage (DEPTH cycles after entry)
//   out_addr  - address leaving the last stage
//   in_flight - a strobe sits in a stage other than the last one
module mv_wb_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          in_flight
);

  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0]    addr_r [DEPTH];
  logic             in_flight_s;

  // Shift strobe and address one stage per cycle; no enable, so stalls upstream
  // never stretch the latency of an entry already in flight.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        addr_r[i]  <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      addr_r[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        addr_r[i]  <= addr_r[i-1];
      end
    end
  end

  // Pending work excluding the last stage: when this is clear the register is
  // empty after the current cycle, so a drain can finish now.
  always_comb begin
    in_flight_s = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_flight_s = in_flight_s | valid_r[i];
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_addr  = addr_r[DEPTH-1];
  assign in_flight = in_flight_s;

endmodule

// File: rtl/mv_row_sequencer.sv
// mv_row_sequencer: control FSM for the matrix-vector multiply datapath.
// Walks num_rows rows of VEC_LEN columns, LANES columns per beat, driving the
// lane address generators and MAC array, then schedules result write-back.
//   clk        - clock; all state changes on the falling edge
//   reset      - asynchronous active-low reset; aborts any job in progress
//   start      - one-cycle job request, honoured only in IDLE
//   num_rows   - rows in the job (0..ROWS, larger values clamp to ROWS)
//   mem_ready  - operand memories accept a beat this cycle
//   busy       - job in progress, from accepted start through done
//   beat_valid - a beat is issued this cycle
//   col_base   - first column of the current beat
//   row_idx    - row of the current beat
//   acc_clear  - first beat of a row: MAC loads rather than accumulates
//   acc_en     - MAC accumulate enable (same as beat_valid)
//   res_we     - result write strobe, PIPE_LAT cycles after a row's last beat
//   res_addr   - row written by res_we
//   done       - one-cycle completion pulse
module mv_row_sequencer
  import mv_pkg::*;
#(
  parameter int VEC_LEN  = VEC_LEN_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(ROWS):0]      num_rows,
  input  logic                       mem_ready,
  output logic                       busy,
  output logic                       beat_valid,
  output logic [$clog2(VEC_LEN)-1:0] col_base,
  output logic [$clog2(ROWS)-1:0]    row_idx,
  output logic                       acc_clear,
  output logic                       acc_en,
  output logic                       res_we,
  output logic [$clog2(ROWS)-1:0]    res_addr,
  output logic                       done
);

  localparam int CW = $clog2(VEC_LEN);
  localparam int RW = $clog2(ROWS);

  localparam logic [CW-1:0] LANE_STEP = CW'(LANES);
  localparam logic [CW-1:0] LAST_COL  = CW'(VEC_LEN - LANES);

  state_t        state_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [RW:0]   nrows_r;
  logic          busy_r;
  logic          done_r;

  logic          beat_s;
  logic          last_col_s;
  logic          last_row_s;
  logic          row_end_s;
  logic          wb_pending_s;

  // A beat goes out whenever RUN meets a ready memory; this cannot be
  // registered without issuing beats the memory did not accept.
  assign beat_s     = (state_r == RUN) && mem_ready;
  assign last_col_s = (col_r == LAST_COL);
  assign last_row_s = ({1'b0, row_r} == (nrows_r - (RW+1)'(1)));
  assign row_end_s  = beat_s && last_col_s;

  // Sequencer FSM: job acceptance, column/row stepping, drain and completion.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      col_r   <= '0;
      row_r   <= '0;
      nrows_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            col_r  <= '0;
            row_r  <= '0;
            if (num_rows == (RW+1)'(0)) begin
              // Empty job: complete without issuing anything.
              nrows_r <= '0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              nrows_r <= (RW+1)'(clamp_rows(int'(num_rows), ROWS));
              state_r <= RUN;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Without mem_ready everything holds, so stalls never skip columns.
          if (mem_ready) begin
            if (last_col_s) begin
              col_r <= '0;
              if (last_row_s) begin
                state_r <= DRAIN;
              end else begin
                row_r <= row_r + RW'(1);
              end
            end else begin
              col_r <= col_r + LANE_STEP;
            end
          end else begin
            col_r <= col_r;
          end
        end
        DRAIN: begin
          // The final write leaves the delay line this cycle once nothing
          // remains behind it, so done lands on the following cycle.
          if (!wb_pending_s) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          // start is not looked at here; it is honoured on the next IDLE cycle.
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  mv_wb_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (RW)
  ) u_wb_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (row_end_s),
    .in_addr   (row_r),
    .out_valid (res_we),
    .out_addr  (res_addr),
    .in_flight (wb_pending_s)
  );

  assign busy       = busy_r;
  assign done       = done_r;
  assign beat_valid = beat_s;
  assign acc_en     = beat_s;
  assign acc_clear  = beat_s && (col_r == CW'(0));
  assign col_base   = col_r;
  assign row_idx    = row_r;

endmodule

// File: tb/tb_mv_row_sequencer.sv
// tb_mv_row_sequencer: directed self-checking bench for mv_row_sequencer.
// Each job drives start/mem_ready per cycle offset from the start pulse, logs
// outputs mid-cycle (rising edge; the DUT updates on the falling edge) and then
// compares the log against hand-derived beat, write, done and busy schedules.
module tb_mv_row_sequencer;
  import mv_pkg::*;

  localparam int N = 2100;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [ROW_W:0]   num_rows;
  logic             mem_ready;
  logic             busy;
  logic             beat_valid;
  logic [COL_W-1:0] col_base;
  logic [ROW_W-1:0] row_idx;
  logic             acc_clear;
  logic             acc_en;
  logic             res_we;
  logic [ROW_W-1:0] res_addr;
  logic             done;

  mv_row_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_rows   (num_rows),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .beat_valid (beat_valid),
    .col_base   (col_base),
    .row_idx    (row_idx),
    .acc_clear  (acc_clear),
    .acc_en     (acc_en),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  logic [31:0] lg_bv   [N];
  logic [31:0] lg_en   [N];
  logic [31:0] lg_clr  [N];
  logic [31:0] lg_we   [N];
  logic [31:0] lg_done [N];
  logic [31:0] lg_busy [N];
  logic [31:0] lg_col  [N];
  logic [31:0] lg_row  [N];
  logic [31:0] lg_addr [N];
  bit          rec_en;
  int          cur_o;

  int exp_bv [N];
  int exp_wr_o[$];
  int exp_wr_a[$];
  int exp_done_o;
  int exp_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Log every output once per cycle, midway between DUT update edges.
  always @(posedge clk) begin
    if (rec_en) begin
      lg_bv[cur_o]   <= 32'(beat_valid);
      lg_en[cur_o]   <= 32'(acc_en);
      lg_clr[cur_o]  <= 32'(acc_clear);
      lg_we[cur_o]   <= 32'(res_we);
      lg_done[cur_o] <= 32'(done);
      lg_busy[cur_o] <= 32'(busy);
      lg_col[cur_o]  <= 32'(col_base);
      lg_row[cur_o]  <= 32'(row_idx);
      lg_addr[cur_o] <= 32'(res_addr);
    end
  end

  function automatic bit ready_of(input int mode, input int o);
    case (mode)
      1:       return (o % 2) == 1;
      2:       return !(o == 16 || o == 17 || o == 18 || o == 20 || o == 21);
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < N; i++) exp_bv[i] = 0;
    exp_wr_o.delete();
    exp_wr_a.delete();
    exp_done_o = -1;
    exp_busy   = 0;
  endtask

  task automatic set_beats(input int a, input int b);
    for (int i = a; i <= b; i++) exp_bv[i] = 1;
  endtask

  task automatic add_wr(input int o, input int a);
    exp_wr_o.push_back(o);
    exp_wr_a.push_back(a);
  endtask

  // Offset 0 carries the start pulse; s2/s3 add extra starts (num_rows=3),
  // rst_at holds reset low for two cycles from that offset.
  task automatic run_job(input int nr, input int mode, input int len,
                         input int s2, input int s3, input int rst_at);
    for (int o = 0; o < len; o++) begin
      @(negedge clk);
      #1;
      cur_o     = o;
      rec_en    = 1'b1;
      start     = (o == 0) || (o == s2) || (o == s3);
      num_rows  = (o == 0) ? (ROW_W+1)'(nr) : (ROW_W+1)'(3);
      mem_ready = ready_of(mode, o);
      reset     = !(rst_at >= 0 && o >= rst_at && o < rst_at + 2);
    end
    @(negedge clk);
    #1;
    rec_en    = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic verify_job(input string nm, input int len);
    int k;
    int w;
    int nd;
    int nb;
    int nexp;
    k = 0; w = 0; nd = 0; nb = 0; nexp = 0;
    for (int o = 0; o < len; o++) begin
      nexp += exp_bv[o];
      check_eq($sformatf("%s beat_valid o=%0d", nm, o), lg_bv[o], 32'(exp_bv[o]));
      check_eq($sformatf("%s acc_en o=%0d", nm, o), lg_en[o], 32'(exp_bv[o]));
      if (lg_bv[o] === 32'd1) begin
        check_eq($sformatf("%s col_base beat %0d", nm, k), lg_col[o], 32'((k % BEATS) * LANES_DEF));
        check_eq($sformatf("%s row_idx beat %0d", nm, k), lg_row[o], 32'(k / BEATS));
        check_eq($sformatf("%s acc_clear beat %0d", nm, k), lg_clr[o], 32'((k % BEATS) == 0));
        k++;
      end else if (o >= 1 && o + 1 < len && exp_bv[o+1] == 1 && lg_busy[o] === 32'd1) begin
        // Stalled cycle: indices must already show the next beat's column/row.
        check_eq($sformatf("%s hold col o=%0d", nm, o), lg_col[o], 32'((k % BEATS) * LANES_DEF));
        check_eq($sformatf("%s hold row o=%0d", nm, o), lg_row[o], 32'(k / BEATS));
      end
      if (lg_we[o] === 32'd1) begin
        if (w < exp_wr_o.size()) begin
          check_eq($sformatf("%s res_we %0d cycle", nm, w), 32'(o), 32'(exp_wr_o[w]));
          check_eq($sformatf("%s res_addr %0d", nm, w), lg_addr[o], 32'(exp_wr_a[w]));
        end else begin
          check_eq($sformatf("%s unexpected res_we cycle", nm), 32'(o), 32'hFFFF_FFFF);
        end
        w++;
      end
      if (lg_done[o] === 32'd1) begin
        nd++;
        check_eq($sformatf("%s done cycle", nm), 32'(o), 32'(exp_done_o));
      end
      if (lg_busy[o] === 32'd1) nb++;
    end
    check_eq($sformatf("%s beat count", nm), 32'(k), 32'(nexp));
    check_eq($sformatf("%s write count", nm), 32'(w), 32'(exp_wr_o.size()));
    check_eq($sformatf("%s done count", nm), 32'(nd), 32'(exp_done_o >= 0));
    check_eq($sformatf("%s busy cycles", nm), 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    start     = 1'b0;
    num_rows  = '0;
    mem_ready = 1'b0;
    rec_en    = 1'b0;
    cur_o     = 0;

    @(posedge clk);
    #1;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst beat_valid", 32'(beat_valid), 32'd0);
    check_eq("rst col_base", 32'(col_base), 32'd0);
    check_eq("rst row_idx", 32'(row_idx), 32'd0);
    check_eq("rst acc_clear", 32'(acc_clear), 32'd0);
    check_eq("rst acc_en", 32'(acc_en), 32'd0);
    check_eq("rst res_we", 32'(res_we), 32'd0);
    check_eq("rst res_addr", 32'(res_addr), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // One row, no stalls: beats 1..16, write at 18, done at 19.
    clear_exp(); set_beats(1, 16); add_wr(18, 0); exp_done_o = 19; exp_busy = 19;
    run_job(1, 0, 25, -1, -1, -1);
    verify_job("j1_row1", 25);

    // Three rows: writes 16 cycles apart.
    clear_exp(); set_beats(1, 48); add_wr(18, 0); add_wr(34, 1); add_wr(50, 2);
    exp_done_o = 51; exp_busy = 51;
    run_job(3, 0, 60, -1, -1, -1);
    verify_job("j2_row3", 60);

    // Two rows, mem_ready alternating: beats on odd offsets only.
    clear_exp();
    for (int o = 1; o <= 63; o += 2) exp_bv[o] = 1;
    add_wr(33, 0); add_wr(65, 1); exp_done_o = 66; exp_busy = 66;
    run_job(2, 1, 75, -1, -1, -1);
    verify_job("j3_toggle", 75);

    // Stall on row 0's last beat (accepted at 19), ready drops again at 20-21.
    clear_exp(); set_beats(1, 15); set_beats(19, 19); set_beats(22, 37);
    add_wr(21, 0); add_wr(39, 1); exp_done_o = 40; exp_busy = 40;
    run_job(2, 2, 50, -1, -1, -1);
    verify_job("j4_laststall", 50);

    // Empty job: done the cycle after start, nothing issued.
    clear_exp(); exp_done_o = 1; exp_busy = 1;
    run_job(0, 0, 10, -1, -1, -1);
    verify_job("j5_zero", 10);

    // Starts while busy and in the done cycle are ignored.
    clear_exp(); set_beats(1, 16); add_wr(18, 0); exp_done_o = 19; exp_busy = 19;
    run_job(1, 0, 30, 5, 19, -1);
    verify_job("j6_ignore", 30);

    // Oversized request clamps to the full 128 rows.
    clear_exp(); set_beats(1, 2048);
    for (int r = 0; r < 128; r++) add_wr(18 + 16 * r, r);
    exp_done_o = 2051; exp_busy = 2051;
    run_job(200, 0, 2060, -1, -1, -1);
    verify_job("j7_clamp", 2060);

    // Reset mid-row (row 1, col 64 at offset 25): job aborted, no write/done.
    clear_exp(); set_beats(1, 24); add_wr(18, 0); exp_busy = 24;
    run_job(3, 0, 60, -1, -1, 25);
    verify_job("j8_abort", 60);
    check_eq("j8 rst busy", lg_busy[25], 32'd0);
    check_eq("j8 rst beat_valid", lg_bv[25], 32'd0);
    check_eq("j8 rst acc_en", lg_en[25], 32'd0);
    check_eq("j8 rst acc_clear", lg_clr[25], 32'd0);
    check_eq("j8 rst col_base", lg_col[25], 32'd0);
    check_eq("j8 rst row_idx", lg_row[25], 32'd0);
    check_eq("j8 rst res_we", lg_we[25], 32'd0);
    check_eq("j8 rst res_addr", lg_addr[25], 32'd0);
    check_eq("j8 rst done", lg_done[25], 32'd0);

    // Normal job after the abort.
    clear_exp(); set_beats(1, 16); add_wr(18, 0); exp_done_o = 19; exp_busy = 19;
    run_job(1, 0, 25, -1, -1, -1);
    verify_job("j9_after_rst", 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
